// File: rtl/uc_ctrl.sv
// ---------------------------------------------------------------------------
// uc_ctrl -- control unit for the single-cycle microcontroller datapath.
//
// Decodes the 6-bit opcode (plus the registered zero flag) into the datapath
// controls and sequences execution with an IDLE / RUN / HALT state machine
// that supports free-running and single-step operation. Retired
// instructions are counted.
//
// Optional feature macro: UC_ILLEGAL_TRAP_EN
//   defined   : an undefined opcode asserts no enables, sets illegal and
//               halts the machine (not counted as retired).
//   undefined : an undefined opcode executes as a NOP (counted), sets the
//               sticky illegal flag and the machine keeps running.
//
// Parameters
//   CNT_W    width of instr_count
//   AUTORUN  1: leave IDLE for RUN without waiting for start
//
// Ports
//   clk          in   clock, all state changes on posedge
//   reset        in   synchronous active-high reset
//   Opcode[5:0]  in   instruction bits [15:10]
//   z            in   registered zero flag
//   start        in   leave IDLE (level)
//   step_mode    in   1: execute only on step_req rising edges
//   step_req     in   single-step request
//   s_inc        out  1: PC+1, 0: PC <- instr[9:0]
//   s_inm        out  1: WD3 <- immediate, 0: WD3 <- ALU
//   we3          out  register file write enable
//   wez          out  zero flag write enable
//   Op[2:0]      out  ALU operation
//   pc_en        out  PC load enable
//   step_ack     out  one-cycle pulse after a stepped instruction
//   halted       out  FSM is in HALT
//   illegal      out  sticky: an undefined opcode was executed
//   instr_count  out  retired instruction count (wraps)
// ---------------------------------------------------------------------------
module uc_ctrl #(
  parameter int CNT_W   = 16,
  parameter bit AUTORUN = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Opcode,
  input  logic             z,
  input  logic             start,
  input  logic             step_mode,
  input  logic             step_req,
  output logic             s_inc,
  output logic             s_inm,
  output logic             we3,
  output logic             wez,
  output logic [2:0]       Op,
  output logic             pc_en,
  output logic             step_ack,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

`ifdef UC_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    C_NOP  = 3'd0,
    C_ALU  = 3'd1,
    C_LI   = 3'd2,
    C_J    = 3'd3,
    C_JZ   = 3'd4,
    C_JNZ  = 3'd5,
    C_HALT = 3'd6,
    C_ILL  = 3'd7
  } cls_t;

  state_t           r_state;
  logic             r_step_prev;
  logic             r_step_ack;
  logic             r_halted;
  logic             r_illegal;
  logic [CNT_W-1:0] r_count;

  logic             w_step_edge;
  logic             w_exec;
  cls_t             w_cls;
  logic             w_trap;
  logic             w_retire;

  assign w_step_edge = step_req & ~r_step_prev;
  // Reset gates exec so an instruction in flight during reset writes nothing.
  assign w_exec      = ~reset & (r_state == ST_RUN) & (~step_mode | w_step_edge);
  assign w_trap      = (w_cls == C_ILL) & TRAP_EN;
  assign w_retire    = w_exec & (w_cls != C_HALT) & ~w_trap;

  // Opcode classification.
  always_comb begin
    w_cls = C_ILL;
    casez (Opcode)
      6'b1?????: w_cls = C_ALU;
      6'b000000: w_cls = C_NOP;
      6'b0001??: w_cls = C_LI;
      6'b0010??: w_cls = C_J;
      6'b0011??: w_cls = C_JZ;
      6'b0100??: w_cls = C_JNZ;
      6'b0111??: w_cls = C_HALT;
      default:   w_cls = C_ILL;
    endcase
  end

  // Datapath controls; zero latency from Opcode, all enables off unless exec.
  always_comb begin
    s_inc = 1'b1;
    s_inm = 1'b0;
    we3   = 1'b0;
    wez   = 1'b0;
    Op    = Opcode[4:2];
    pc_en = 1'b0;
    if (w_exec) begin
      pc_en = 1'b1;
      case (w_cls)
        C_ALU: begin
          we3 = 1'b1;
          wez = 1'b1;
        end
        C_LI: begin
          s_inm = 1'b1;
          we3   = 1'b1;
        end
        C_J:    s_inc = 1'b0;
        // z is the flag registered before this instruction.
        C_JZ:   s_inc = ~z;
        C_JNZ:  s_inc = z;
        C_HALT: pc_en = 1'b0;
        C_ILL:  pc_en = ~TRAP_EN;
        default: pc_en = 1'b1;
      endcase
    end else begin
      pc_en = 1'b0;
    end
  end

  // Sequencer FSM, step edge history, status flags and retire counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_halted    <= 1'b0;
      r_step_prev <= 1'b0;
      r_step_ack  <= 1'b0;
      r_illegal   <= 1'b0;
      r_count     <= {CNT_W{1'b0}};
    end else begin
      r_step_prev <= step_req;
      r_step_ack  <= w_exec & step_mode;
      if (w_exec && (w_cls == C_ILL)) begin
        r_illegal <= 1'b1;
      end else begin
        r_illegal <= r_illegal;
      end
      if (w_retire) begin
        r_count <= r_count + CNT_W'(1'b1);
      end else begin
        r_count <= r_count;
      end
      case (r_state)
        ST_IDLE: begin
          if (start || AUTORUN) begin
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
          r_halted <= 1'b0;
        end
        ST_RUN: begin
          if (w_exec && ((w_cls == C_HALT) || w_trap)) begin
            r_state  <= ST_HALT;
            r_halted <= 1'b1;
          end else begin
            r_state  <= ST_RUN;
            r_halted <= 1'b0;
          end
        end
        ST_HALT: begin
          r_state  <= ST_HALT;
          r_halted <= 1'b1;
        end
        default: begin
          r_state  <= ST_IDLE;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  assign step_ack    = r_step_ack;
  assign halted      = r_halted;
  assign illegal     = r_illegal;
  assign instr_count = r_count;

endmodule

// File: tb/tb_uc_ctrl.sv
// Bench for uc_ctrl: table of decode vectors, hand-written sequences for
// stepping / halt / illegal / wrap / reset, then random stimulus against an
// opcode-classification reference model. A second instance with CNT_W=4
// shares all inputs to exercise counter wrap.
module tb_uc_ctrl;

`ifdef UC_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic [5:0] opc = 6'd0;
  logic       z = 1'b0, start = 1'b0, step_mode = 1'b0, step_req = 1'b0;

  logic        s_inc, s_inm, we3, wez, pc_en, step_ack, halted, illegal;
  logic [2:0]  op;
  logic [15:0] cnt;
  logic        s_inc4, s_inm4, we34, wez4, pc_en4, step_ack4, halted4, illegal4;
  logic [2:0]  op4;
  logic [3:0]  cnt4;

  uc_ctrl #(.CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .Opcode(opc), .z(z), .start(start),
    .step_mode(step_mode), .step_req(step_req),
    .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez), .Op(op), .pc_en(pc_en),
    .step_ack(step_ack), .halted(halted), .illegal(illegal), .instr_count(cnt));

  uc_ctrl #(.CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .Opcode(opc), .z(z), .start(start),
    .step_mode(step_mode), .step_req(step_req),
    .s_inc(s_inc4), .s_inm(s_inm4), .we3(we34), .wez(wez4), .Op(op4), .pc_en(pc_en4),
    .step_ack(step_ack4), .halted(halted4), .illegal(illegal4), .instr_count(cnt4));

  wire [7:0] ctl  = {s_inc, s_inm, we3, wez, op, pc_en};
  wire [7:0] ctl4 = {s_inc4, s_inm4, we34, wez4, op4, pc_en4};

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: 0 idle, 1 run, 2 halt.
  int          m_state;
  bit          m_prev, m_ack, m_ill;
  int unsigned m_cnt;
  bit          m_exec;
  int          m_kind;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Kinds: 0 NOP 1 ALU 2 LI 3 J 4 JZ 5 JNZ 6 HALT 7 illegal
  function automatic int kind_of(input logic [5:0] o);
    int g;
    if (o >= 6'd32) return 1;
    g = int'(o) / 4;
    case (g)
      0: return (o == 6'd0) ? 0 : 7;
      1: return 2;
      2: return 3;
      3: return 4;
      4: return 5;
      7: return 6;
      default: return 7;
    endcase
  endfunction

  // Settle, then compare every output against the model.
  task automatic tick_pre();
    bit e_sinc, e_sinm, e_we3, e_wez, e_pc;
    logic [2:0] e_op;
    logic [7:0] e_ctl;
    #1;
    m_kind = kind_of(opc);
    m_exec = !reset && (m_state == 1) && (!step_mode || (step_req && !m_prev));
    e_sinc = 1'b1; e_sinm = 1'b0; e_we3 = 1'b0; e_wez = 1'b0; e_pc = 1'b0;
    e_op = 3'((int'(opc) / 4) % 8);
    if (m_exec) begin
      e_pc = 1'b1;
      case (m_kind)
        1: begin e_we3 = 1'b1; e_wez = 1'b1; end
        2: begin e_sinm = 1'b1; e_we3 = 1'b1; end
        3: e_sinc = 1'b0;
        4: e_sinc = !z;
        5: e_sinc = z;
        6: e_pc = 1'b0;
        7: e_pc = !TRAP;
        default: e_pc = 1'b1;
      endcase
    end
    e_ctl = {e_sinc, e_sinm, e_we3, e_wez, e_op, e_pc};
    chk("ctrl", {24'd0, ctl}, {24'd0, e_ctl});
    chk("ctrl4", {24'd0, ctl4}, {24'd0, e_ctl});
    chk("status", {29'd0, step_ack, halted, illegal}, {29'd0, m_ack, (m_state == 2), m_ill});
    chk("status4", {29'd0, step_ack4, halted4, illegal4}, {29'd0, m_ack, (m_state == 2), m_ill});
    chk("count16", {16'd0, cnt}, m_cnt % 65536);
    chk("count4", {28'd0, cnt4}, m_cnt % 16);
  endtask

  // Advance the model with the pre-edge inputs, then cross the clock edge.
  task automatic tick_post();
    int ns;
    if (reset) begin
      m_state = 0; m_prev = 0; m_ack = 0; m_ill = 0; m_cnt = 0;
    end else begin
      ns = m_state;
      if (m_state == 0 && start) ns = 1;
      if (m_exec) begin
        if (m_kind == 6) ns = 2;
        if (m_kind == 7) begin
          m_ill = 1;
          if (TRAP) ns = 2;
        end
        if (m_kind != 6 && !(m_kind == 7 && TRAP)) m_cnt = m_cnt + 1;
      end
      m_ack   = m_exec && step_mode;
      m_prev  = step_req;
      m_state = ns;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cyc();
    tick_pre();
    tick_post();
  endtask

  task automatic reset_start();
    reset = 1'b1; start = 1'b0; step_mode = 1'b0; step_req = 1'b0; opc = 6'd0; z = 1'b0;
    cyc();
    reset = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  typedef struct {
    logic [5:0] opc;
    logic       z;
    logic [7:0] exp;   // {s_inc, s_inm, we3, wez, Op, pc_en}
    string      name;
  } vec_t;

  vec_t tbl[10];
  int   acks;
  int   c0;

  initial begin
    tbl[0] = '{6'b000110, 1'b0, 8'b1110_001_1, "t1_li"};
    tbl[1] = '{6'b100000, 1'b0, 8'b1011_000_1, "t1_alu"};
    tbl[2] = '{6'b000000, 1'b0, 8'b1000_000_1, "t1_nop"};
    tbl[3] = '{6'b111111, 1'b1, 8'b1011_111_1, "alu_ff"};
    tbl[4] = '{6'b101010, 1'b0, 8'b1011_010_1, "alu_op2"};
    tbl[5] = '{6'b001001, 1'b1, 8'b0000_010_1, "j"};
    tbl[6] = '{6'b001100, 1'b1, 8'b0000_011_1, "jz_taken"};
    tbl[7] = '{6'b001111, 1'b0, 8'b1000_011_1, "jz_not"};
    tbl[8] = '{6'b010000, 1'b1, 8'b1000_100_1, "jnz_not"};
    tbl[9] = '{6'b010010, 1'b0, 8'b0000_100_1, "jnz_taken"};

    // Bring state out of X before any model comparison.
    m_state = 0; m_prev = 0; m_ack = 0; m_ill = 0; m_cnt = 0;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_state", {28'd0, step_ack, halted, illegal, pc_en}, 32'd0);
    chk("reset_count", {16'd0, cnt}, 32'd0);

    // Decode table (tests 1 and 2).
    reset_start();
    for (int i = 0; i < 10; i++) begin
      opc = tbl[i].opc;
      z   = tbl[i].z;
      tick_pre();
      chk(tbl[i].name, {24'd0, ctl}, {24'd0, tbl[i].exp});
      tick_post();
      if (i == 2) chk("t1_count3", {16'd0, cnt}, 32'd3);
    end
    chk("table_count", {16'd0, cnt}, 32'd10);

    // Test 3: step_req held high for 10 cycles -> exactly one exec.
    reset_start();
    step_mode = 1'b1;
    cyc();
    acks = 0;
    step_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick_pre();
      if (step_ack) acks++;
      tick_post();
    end
    step_req = 1'b0;
    tick_pre();
    if (step_ack) acks++;
    tick_post();
    chk("step_one_ack", acks, 32'd1);
    chk("step_count", {16'd0, cnt}, 32'd1);

    // Test 4: HALT at address 3.
    reset_start();
    for (int i = 0; i < 3; i++) cyc();
    opc = 6'b011101;
    tick_pre();
    chk("halt_pc_en", {31'd0, pc_en}, 32'd0);
    chk("halt_not_yet", {31'd0, halted}, 32'd0);
    tick_post();
    opc = 6'd0;
    tick_pre();
    chk("halted", {31'd0, halted}, 32'd1);
    chk("halt_count", {16'd0, cnt}, 32'd3);
    tick_post();
    step_mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step_req = i[0];
      cyc();
    end
    step_mode = 1'b0;
    tick_pre();
    chk("halt_frozen", {16'd0, cnt}, 32'd3);
    chk("halt_no_ack", {31'd0, step_ack}, 32'd0);
    tick_post();

    // Test 5: illegal opcode.
    reset_start();
    opc = 6'b010110;
    tick_pre();
    chk("ill_pc_en", {31'd0, pc_en}, {31'd0, !TRAP});
    tick_post();
    opc = 6'd0;
    tick_pre();
    chk("ill_flag", {31'd0, illegal}, 32'd1);
    chk("ill_halted", {31'd0, halted}, {31'd0, TRAP});
    chk("ill_count", {16'd0, cnt}, TRAP ? 32'd0 : 32'd1);
    tick_post();

    // Test 6: counter wrap on the 4-bit instance, then reset mid-run.
    reset_start();
    for (int i = 0; i < 17; i++) cyc();
    tick_pre();
    chk("wrap4", {28'd0, cnt4}, 32'd1);
    chk("wrap16", {16'd0, cnt}, 32'd17);
    tick_post();
    opc = 6'b110001;
    reset = 1'b1;
    tick_pre();
    chk("rst_mid_en", {29'd0, we3, wez, pc_en}, 32'd0);
    tick_post();
    reset = 1'b0;
    tick_pre();
    chk("rst_idle_en", {29'd0, we3, wez, pc_en}, 32'd0);
    chk("rst_idle_cnt", {16'd0, cnt}, 32'd0);
    tick_post();

    // Random stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(31) == 0);
      start     = ($urandom_range(3) == 0);
      step_mode = ($urandom_range(2) == 0);
      step_req  = 1'($urandom_range(1));
      z         = 1'($urandom_range(1));
      opc       = 6'($urandom_range(63));
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
